// File: rtl/cpu_trace_pkg.sv
// Shared types and default widths for the CPU retired-instruction trace capture.
package cpu_trace_pkg;

    localparam int DEF_ILEN  = 32;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        TRIG_IMM   = 2'd0,
        TRIG_ZERO  = 2'd1,
        TRIG_INSTR = 2'd2,
        TRIG_ALU   = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_ILEN-1:0] instruction;
        logic [DEF_XLEN-1:0] alu_result;
        logic                zero;
    } trace_entry_t;

endpackage

// File: rtl/trace_trigger_match.sv
// Combinational trigger decision for one observed sample against the latched run configuration.
module trace_trigger_match
    import cpu_trace_pkg::*;
#(
    parameter int ILEN = DEF_ILEN,
    parameter int XLEN = DEF_XLEN
) (
    input  trig_mode_e       mode,
    input  logic [ILEN-1:0]  match_pattern,
    input  logic [ILEN-1:0]  match_mask,
    input  logic [ILEN-1:0]  instruction,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             zero,
    output logic             hit
);

    logic [ILEN-1:0] alu_cmp;

    // The ALU compare always happens at instruction width; narrow results are zero-extended.
    generate
        if (XLEN >= ILEN) begin : g_alu_trunc
            assign alu_cmp = alu_result[ILEN-1:0];
        end else begin : g_alu_ext
            assign alu_cmp = {{(ILEN-XLEN){1'b0}}, alu_result};
        end
    endgenerate

    always_comb begin
        hit = 1'b0;
        case (mode)
            TRIG_IMM:   hit = 1'b1;
            TRIG_ZERO:  hit = zero;
            TRIG_INSTR: hit = ((instruction & match_mask) == match_pattern);
            TRIG_ALU:   hit = (alu_cmp == match_pattern);
            default:    hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_trace_capture.sv
// Triggerable circular trace buffer for the retired instruction stream, drained oldest-first over valid/ready.
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int ILEN  = DEF_ILEN,
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic [1:0]       trig_mode,
    input  logic [ILEN-1:0]  match_pattern,
    input  logic [ILEN-1:0]  match_mask,
    input  logic [CW-1:0]    post_count,
    input  logic             sample_valid,
    input  logic [ILEN-1:0]  instruction,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             zero,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [ILEN-1:0]  rd_instruction,
    output logic [XLEN-1:0]  rd_alu_result,
    output logic             rd_zero,
    output logic             rd_last,
    output logic             busy,
    output logic             triggered,
    output logic [CW-1:0]    entries
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);

    state_e          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   post_cnt;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   post_cfg;
    trig_mode_e      mode_q;
    logic [ILEN-1:0] pattern_q;
    logic [ILEN-1:0] mask_q;

    logic [ILEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_alu   [DEPTH];
    logic [DEPTH-1:0] mem_zero;

    logic            hit;
    logic            capture;
    logic [AW-1:0]   wr_ptr_inc;
    logic [CW-1:0]   entries_inc;

    trace_trigger_match #(
        .ILEN (ILEN),
        .XLEN (XLEN)
    ) u_match (
        .mode          (mode_q),
        .match_pattern (pattern_q),
        .match_mask    (mask_q),
        .instruction   (instruction),
        .alu_result    (alu_result),
        .zero          (zero),
        .hit           (hit)
    );

    assign capture     = sample_valid && ((state == PRE) || (state == POST));
    assign wr_ptr_inc  = wr_ptr + AW'(1);
    assign entries_inc = (entries == FULL) ? entries : entries + CW'(1);

    always_ff @(posedge clock) begin
        if (reset && capture) begin
            mem_instr[wr_ptr] <= instruction;
            mem_alu[wr_ptr]   <= alu_result;
            mem_zero[wr_ptr]  <= zero;
        end
    end

    // Entering DRAIN computes the oldest slot from the post-write pointer and count of the final sample.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            entries   <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            post_cfg  <= '0;
            mode_q    <= TRIG_IMM;
            pattern_q <= '0;
            mask_q    <= '0;
            rd_valid  <= 1'b0;
            triggered <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= PRE;
                        wr_ptr    <= '0;
                        entries   <= '0;
                        post_cfg  <= (post_count > MAX_POST) ? MAX_POST : post_count;
                        mode_q    <= trig_mode_e'(trig_mode);
                        pattern_q <= match_pattern;
                        mask_q    <= match_mask;
                    end
                end
                PRE: begin
                    if (sample_valid) begin
                        wr_ptr  <= wr_ptr_inc;
                        entries <= entries_inc;
                        if (hit) begin
                            triggered <= 1'b1;
                            post_cnt  <= post_cfg;
                            if (post_cfg == '0) begin
                                state     <= DRAIN;
                                rd_valid  <= 1'b1;
                                rd_ptr    <= wr_ptr_inc - entries_inc[AW-1:0];
                                remaining <= entries_inc;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        wr_ptr   <= wr_ptr_inc;
                        entries  <= entries_inc;
                        post_cnt <= post_cnt - CW'(1);
                        if (post_cnt == CW'(1)) begin
                            state     <= DRAIN;
                            rd_valid  <= 1'b1;
                            rd_ptr    <= wr_ptr_inc - entries_inc[AW-1:0];
                            remaining <= entries_inc;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr    <= rd_ptr + AW'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state     <= IDLE;
                            rd_valid  <= 1'b0;
                            triggered <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign rd_last        = rd_valid && (remaining == CW'(1));
    assign rd_instruction = rd_valid ? mem_instr[rd_ptr] : '0;
    assign rd_alu_result  = rd_valid ? mem_alu[rd_ptr]   : '0;
    assign rd_zero        = rd_valid && mem_zero[rd_ptr];

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed self-checking bench for cpu_trace_capture at DEPTH=8.
module tb_cpu_trace_capture;

    logic        clock;
    logic        reset;
    logic        arm;
    logic [1:0]  trig_mode;
    logic [31:0] match_pattern;
    logic [31:0] match_mask;
    logic [3:0]  post_count;
    logic        sample_valid;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic        zero;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_instruction;
    logic [31:0] rd_alu_result;
    logic        rd_zero;
    logic        rd_last;
    logic        busy;
    logic        triggered;
    logic [3:0]  entries;

    int vectors;
    int miscompares;

    logic [31:0] expInstr[$];
    logic [31:0] expAlu[$];
    logic        expZero[$];

    cpu_trace_capture #(
        .ILEN  (32),
        .XLEN  (32),
        .DEPTH (8),
        .CW    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .arm            (arm),
        .trig_mode      (trig_mode),
        .match_pattern  (match_pattern),
        .match_mask     (match_mask),
        .post_count     (post_count),
        .sample_valid   (sample_valid),
        .instruction    (instruction),
        .alu_result     (alu_result),
        .zero           (zero),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_instruction (rd_instruction),
        .rd_alu_result  (rd_alu_result),
        .rd_zero        (rd_zero),
        .rd_last        (rd_last),
        .busy           (busy),
        .triggered      (triggered),
        .entries        (entries)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] alu, input logic z);
        sample_valid = v;
        instruction  = ins;
        alu_result   = alu;
        zero         = z;
        step();
        sample_valid = 1'b0;
        zero         = 1'b0;
    endtask

    task automatic doArm(input logic [1:0] mode, input logic [31:0] pattern, input logic [31:0] mask,
                         input logic [3:0] post);
        trig_mode     = mode;
        match_pattern = pattern;
        match_mask    = mask;
        post_count    = post;
        arm           = 1'b1;
        step();
        arm = 1'b0;
        checkOutput("arm_busy", busy, 1);
        checkOutput("arm_entries", entries, 0);
        checkOutput("arm_triggered", triggered, 0);
    endtask

    task automatic pushExp(input logic [31:0] ins, input logic [31:0] alu, input logic z);
        expInstr.push_back(ins);
        expAlu.push_back(alu);
        expZero.push_back(z);
    endtask

    task automatic clearExp();
        expInstr.delete();
        expAlu.delete();
        expZero.delete();
    endtask

    // stallMask bit c holds rd_ready low on drain cycle c; beyond 16 cycles ready stays high.
    task automatic drainExpect(input string tag, input logic [15:0] stallMask);
        int n;
        int idx;
        int cyc;
        n   = expInstr.size();
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 64) begin
            checkOutput({tag, "_valid"}, rd_valid, 1);
            checkOutput({tag, "_instr"}, rd_instruction, expInstr[idx]);
            checkOutput({tag, "_alu"}, rd_alu_result, expAlu[idx]);
            checkOutput({tag, "_zero"}, rd_zero, expZero[idx]);
            checkOutput({tag, "_last"}, rd_last, (idx == n - 1));
            rd_ready = (cyc < 16) ? ~stallMask[cyc] : 1'b1;
            step();
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        if (idx < n) checkOutput({tag, "_timeout"}, idx, n);
        checkOutput({tag, "_end_busy"}, busy, 0);
        checkOutput({tag, "_end_valid"}, rd_valid, 0);
        checkOutput({tag, "_end_trig"}, triggered, 0);
    endtask

    initial begin
        logic [31:0] seq3 [9];
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        arm           = 1'b0;
        trig_mode     = 2'd0;
        match_pattern = '0;
        match_mask    = '0;
        post_count    = '0;
        sample_valid  = 1'b0;
        instruction   = '0;
        alu_result    = '0;
        zero          = 1'b0;
        rd_ready      = 1'b0;

        step();
        step();
        reset = 1'b1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_trig", triggered, 0);
        checkOutput("rst_entries", entries, 0);
        checkOutput("rst_last", rd_last, 0);
        checkOutput("rst_instr", rd_instruction, 0);

        // Immediate trigger, three post samples; the fifth sample lands in DRAIN and is dropped.
        $display("[TB] immediate trigger");
        doArm(2'd0, 32'h0, 32'h0, 4'd3);
        clearExp();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h13 + i, 32'hA000 + i, i[0]);
            if (i < 4) pushExp(32'h13 + i, 32'hA000 + i, i[0]);
        end
        checkOutput("imm_entries", entries, 4);
        checkOutput("imm_trig", triggered, 1);
        drainExpect("imm", 16'h0000);
        checkOutput("imm_entries_hold", entries, 4);

        // Zero-flag trigger on sample 12 of 20; buffer wraps, keeping samples 7..14.
        $display("[TB] zero trigger with wrap");
        doArm(2'd1, 32'h0, 32'h0, 4'd2);
        clearExp();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 32'h1000 + i, (i == 12));
            if (i == 11) checkOutput("zero_pre_trig", triggered, 0);
            if (i == 12) checkOutput("zero_post_trig", triggered, 1);
            if (i >= 7 && i <= 14) pushExp(32'h100 + i, 32'h1000 + i, (i == 12));
        end
        checkOutput("zero_entries", entries, 8);
        drainExpect("zero", 16'h0000);

        // Opcode match on BEQ after six ADDIs; BEQ ends up third from the newest entry.
        $display("[TB] instruction mask trigger");
        for (int i = 0; i < 6; i++) seq3[i] = 32'h00008093 + (i << 20);
        seq3[6] = 32'h00208463;
        seq3[7] = 32'h00608093;
        seq3[8] = 32'h00708093;
        doArm(2'd2, 32'h63, 32'h7F, 4'd2);
        clearExp();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, seq3[i], 32'h50 + i, (i == 6));
            if (i == 5) checkOutput("instr_pre_trig", triggered, 0);
            if (i == 6) checkOutput("instr_post_trig", triggered, 1);
            if (i >= 1) pushExp(seq3[i], 32'h50 + i, (i == 6));
        end
        checkOutput("instr_entries", entries, 8);
        checkOutput("instr_beq_slot", expInstr[5], 32'h00208463);
        drainExpect("instr", 16'h0000);

        // ALU-result trigger, then drain with ready low 3, high 1, low 2.
        $display("[TB] alu trigger with backpressure");
        doArm(2'd3, 32'h20, 32'h0, 4'd1);
        clearExp();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h400 + i, i * 32'h10, 1'b0);
            pushExp(32'h400 + i, i * 32'h10, 1'b0);
        end
        checkOutput("bp_entries", entries, 4);
        drainExpect("bp", 16'h0037);

        // Reset mid-POST aborts the run; a fresh arm then captures normally.
        $display("[TB] reset during post");
        doArm(2'd0, 32'h0, 32'h0, 4'd5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h500 + i, 32'h0, 1'b0);
        checkOutput("abort_busy_before", busy, 1);
        checkOutput("abort_valid_before", rd_valid, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", rd_valid, 0);
        checkOutput("abort_entries", entries, 0);
        checkOutput("abort_trig", triggered, 0);
        doArm(2'd0, 32'h0, 32'h0, 4'd1);
        clearExp();
        applyStimulus(1'b1, 32'h600, 32'h66, 1'b1);
        applyStimulus(1'b1, 32'h601, 32'h67, 1'b0);
        pushExp(32'h600, 32'h66, 1'b1);
        pushExp(32'h601, 32'h67, 1'b0);
        checkOutput("rearm_entries", entries, 2);
        drainExpect("rearm", 16'h0000);

        // post_count=15 clamps to 7; invalid cycles carry zero=1 and junk that must not be written.
        $display("[TB] post clamp with gaps");
        doArm(2'd1, 32'h0, 32'h0, 4'd15);
        clearExp();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, 32'h300 + k, k, (k == 4));
            if (k == 10) checkOutput("clamp_not_done", rd_valid, 0);
            if (k == 11) begin
                checkOutput("clamp_done", rd_valid, 1);
                checkOutput("clamp_entries", entries, 8);
            end
            if (k >= 4 && k <= 11) pushExp(32'h300 + k, k, (k == 4));
            applyStimulus(1'b0, 32'hDEAD0000 + k, 32'hFFFF, 1'b1);
        end
        drainExpect("clamp", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Parametrised, triggerable trace buffer that observes the CPU's retired instruction stream (instruction, ALU_result, zero) and records it in a circular buffer.
- Freezes the buffer on a selectable trigger plus a programmable number of post-trigger samples.
- Drains the frozen window oldest-first over a valid/ready port.
- Sits beside CPU at top level; feeds the UART debug path and self-checking benches.

Parameters:
- ILEN, 32, instruction width.
- XLEN, 32, ALU result width.
- DEPTH, 16, buffer entries; power of two, >= 4.
- CW, $clog2(DEPTH)+1, width of count fields (derived).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- arm  in  1  one-cycle start pulse; honoured only in IDLE.
- trig_mode  in  2  0 immediate, 1 zero==1, 2 (instruction & match_mask)==match_pattern, 3 alu_result[ILEN-1:0]==match_pattern.
- match_pattern  in  ILEN  trigger compare value.
- match_mask  in  ILEN  instruction compare mask.
- post_count  in  CW  samples captured after the trigger sample.
- sample_valid  in  1  instruction/alu_result/zero are valid this cycle.
- instruction  in  ILEN  observed instruction.
- alu_result  in  XLEN  observed ALU result.
- zero  in  1  observed zero flag.
- rd_ready  in  1  consumer accepts the current entry.
- rd_valid  out  1  drain entry valid.
- rd_instruction  out  ILEN  drained instruction.
- rd_alu_result  out  XLEN  drained ALU result.
- rd_zero  out  1  drained zero flag.
- rd_last  out  1  final entry of the window.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger has fired in the current run.
- entries  out  CW  valid entries in the buffer (saturates at DEPTH).

Behaviour:
- Reset (reset==0 at posedge): state IDLE; wr_ptr, rd_ptr, entries and the post counter go to 0. All outputs are 0. Buffer contents are don't-care. Reset in any state, including mid-drain, aborts the run. No partial drain resumes.
- States: IDLE -> PRE -> POST -> DRAIN -> IDLE.
- IDLE:
  - arm==1 -> PRE next cycle; entries and wr_ptr are cleared.
  - post_count is latched, clamped to DEPTH-1 so the trigger entry always survives.
  - trig_mode, match_pattern and match_mask are also latched.
  - The sample present in the arm cycle is not captured.
- PRE, on each sample_valid:
  - Write {instruction, alu_result, zero} at wr_ptr; wr_ptr wraps modulo DEPTH; entries saturates at DEPTH.
  - The trigger is evaluated on the same sample. On a hit that sample is written, triggered=1 next cycle, and the post counter loads the latched post_count.
  - If post_count==0 -> DRAIN, otherwise -> POST.
  - sample_valid==0 -> no write and no trigger.
- POST: each valid sample is written and decrements the post counter; on the write that reaches 0 -> DRAIN next cycle. Further trigger hits are ignored.
- DRAIN:
  - Entry cycle: rd_ptr = wr_ptr - entries (mod DEPTH).
  - rd_valid is asserted in the first DRAIN cycle. Read data comes combinationally from the register array at rd_ptr.
  - Transfer occurs when rd_valid && rd_ready: rd_ptr increments and the remaining count decrements. The next entry appears the following cycle with no bubble.
  - rd_last=1 when remaining==1.
  - While rd_ready==0, rd_* is held stable.
  - The transfer with rd_last -> IDLE next cycle. rd_valid drops, triggered clears, entries holds its final value until the next arm.
- arm outside IDLE is ignored. sample_valid is ignored in DRAIN and IDLE.
- Width rules: all pointer arithmetic is modulo DEPTH. The ALU compare uses the low ILEN bits, zero-extended if XLEN<ILEN.

Decomposition:
- Package cpu_trace_pkg holds:
  - trig_mode_e (TRIG_IMM, TRIG_ZERO, TRIG_INSTR, TRIG_ALU);
  - state_e (IDLE, PRE, POST, DRAIN);
  - default width constants;
  - a trace_entry_t struct built from the default widths.
- Sub-module trace_trigger_match: combinational match of the current sample against the latched mode, pattern and mask; outputs hit.
- Storage is a flop array in the top module.

Test Plan:
- DEPTH=8, trig_mode=0, post_count=3: arm, then 5 valid samples with instruction=0x13+i, i=0..4 -> exactly 4 entries drained (i=0..3); rd_last on i=3; busy=0 the cycle after.
- trig_mode=1, post_count=2, 20 valid samples, zero=1 only on sample 12 -> 8 entries drained, samples 7..14 oldest-first; entries=8.
- trig_mode=2, mask=0x7F, pattern=0x63, stream of ADDI, then BEQ 0x00208463, then 2 more -> BEQ is entry index entries-3 with post_count=2; triggered=1 from the cycle after the BEQ sample.
- Drain backpressure: rd_ready low 3 cycles, high 1, low 2 -> rd_* stable while low, one pop per handshake, no loss or duplication.
- Reset low for 1 cycle in POST after 3 samples -> next cycle busy=0, rd_valid=0, entries=0; a fresh arm captures correctly.
- post_count=15 with DEPTH=8 and sample_valid gaps every other cycle -> clamped to 7 post samples; no writes on invalid cycles; drain shows 8 entries ending 7 samples after the trigger.
